// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg
//   Shared pipeline definitions for the hazard/stall control block:
//   - hsu_state_e            : FSM state encoding (RUN, MEM_WAIT, HALT)
//   - DEFAULT_TIMEOUT_CYCLES : MEM_WAIT cycles before a memory timeout
//   - DEFAULT_CNT_W          : default width of the stall statistics counter
//   - reg_hazard()           : non-zero destination register matches an ID source
package hazard_stall_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } hsu_state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int unsigned DEFAULT_CNT_W          = 16;

  // Register 0 is hard-wired to zero, so a write to it never creates a hazard.
  function automatic logic reg_hazard(input logic [4:0] dst,
                                      input logic [4:0] src_a,
                                      input logic [4:0] src_b);
    return (dst != 5'd0) && ((dst == src_a) || (dst == src_b));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// sat_counter
//   Parameterized-width incrementer that sticks at all-ones.
//   Ports:
//     clk_i   : clock, rising edge
//     rst_i   : asynchronous active-low reset, clears the count
//     inc_i   : increment request for this cycle
//     count_o : current count (registered)
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Pipeline hazard / stall controller. A three-state FSM (RUN, MEM_WAIT,
//   HALT) handles data-memory waits and timeouts; in RUN it also detects
//   load-use and branch data hazards and requests branch flushes. All
//   control outputs are combinational (Mealy) from state and inputs.
//   Ports:
//     clk_i, rst_i                      : clock, async active-low reset
//     IDEX_* / EXMEM_* / IFID_*, Branch_i : pipeline register info
//     DMem_req_i, DMem_ready_i          : data-memory handshake
//     PCWrite_o, IFIDWrite_o            : PC / IF-ID register enables
//     IDEX_Bubble_o, IFID_Flush_o       : bubble insertion / IF-ID flush
//     MemStall_o, Timeout_o             : memory freeze / timeout flags
//     StallCount_o                      : saturating count of PC-stall cycles
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic             IDEX_RegWrite_i,
  input  logic [4:0]       IDEX_RegisterRt_i,
  input  logic [4:0]       IDEX_RegisterRd_i,
  input  logic             EXMEM_MemRead_i,
  input  logic [4:0]       EXMEM_RegisterRd_i,
  input  logic [4:0]       IFID_RegisterRs_i,
  input  logic [4:0]       IFID_RegisterRt_i,
  input  logic             Branch_i,
  input  logic             DMem_req_i,
  input  logic             DMem_ready_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IDEX_Bubble_o,
  output logic             IFID_Flush_o,
  output logic             MemStall_o,
  output logic             Timeout_o,
  output logic [CNT_W-1:0] StallCount_o
);

  // The wait counter only ever holds 0 .. TIMEOUT_CYCLES-1; the cycle that
  // would make it reach TIMEOUT_CYCLES moves the FSM to HALT instead.
  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  hsu_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic data_stall;
  logic run_rules;
  logic pc_write, ifid_write, bubble, flush, mem_stall, timeout;

  // Data hazards: load-use in EX, branch on an ALU result in EX, and branch
  // on a load still in MEM (the latter gives the second stall cycle of a
  // load-then-branch pair).
  assign data_stall =
      (IDEX_MemRead_i && reg_hazard(IDEX_RegisterRt_i, IFID_RegisterRs_i, IFID_RegisterRt_i)) ||
      (Branch_i && IDEX_RegWrite_i &&
       reg_hazard(IDEX_RegisterRd_i, IFID_RegisterRs_i, IFID_RegisterRt_i)) ||
      (Branch_i && EXMEM_MemRead_i &&
       reg_hazard(EXMEM_RegisterRd_i, IFID_RegisterRs_i, IFID_RegisterRt_i));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    run_rules  = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    bubble     = 1'b0;
    flush      = 1'b0;
    mem_stall  = 1'b0;
    timeout    = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (DMem_req_i && !DMem_ready_i) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          mem_stall  = 1'b1;
          state_d    = ST_MEM_WAIT;
        end else begin
          run_rules = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!DMem_ready_i) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          mem_stall  = 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = ST_HALT;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else begin
          // Access completes: this cycle already behaves like RUN.
          run_rules = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_HALT: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        mem_stall  = 1'b1;
        timeout    = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (run_rules) begin
      if (data_stall) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        bubble     = 1'b1;
      end else if (Branch_i) begin
        flush = 1'b1;
      end
    end

    // Outputs follow reset immediately, independent of the clock.
    if (!rst_i) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      bubble     = 1'b1;
      flush      = 1'b0;
      mem_stall  = 1'b0;
      timeout    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (!pc_write),
    .count_o (StallCount_o)
  );

  assign PCWrite_o     = pc_write;
  assign IFIDWrite_o   = ifid_write;
  assign IDEX_Bubble_o = bubble;
  assign IFID_Flush_o  = flush;
  assign MemStall_o    = mem_stall;
  assign Timeout_o     = timeout;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit
//   Directed and randomized checks of hazard_stall_unit against a
//   behavioural model. A second instance with TIMEOUT_CYCLES=4 and its own
//   reset is used for the timeout/HALT scenario.
module tb_hazard_stall_unit;

  localparam int TO_MAIN = 255;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk_i = 1'b0;
  logic rst_n, rst4_n;
  logic       mr_ex, rw_ex, mr_mem, br, req, rdy;
  logic [4:0] rt_ex, rd_ex, rd_mem, rs_id, rt_id;

  logic pcw, ifw, bub, fl, ms, to;
  logic [CNT_W-1:0] cnt;
  logic pcw4, ifw4, bub4, fl4, ms4, to4;
  logic [CNT_W-1:0] cnt4;

  always #5 clk_i = ~clk_i;

  hazard_stall_unit #(.TIMEOUT_CYCLES(TO_MAIN), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_n),
    .IDEX_MemRead_i(mr_ex), .IDEX_RegWrite_i(rw_ex),
    .IDEX_RegisterRt_i(rt_ex), .IDEX_RegisterRd_i(rd_ex),
    .EXMEM_MemRead_i(mr_mem), .EXMEM_RegisterRd_i(rd_mem),
    .IFID_RegisterRs_i(rs_id), .IFID_RegisterRt_i(rt_id), .Branch_i(br),
    .DMem_req_i(req), .DMem_ready_i(rdy),
    .PCWrite_o(pcw), .IFIDWrite_o(ifw), .IDEX_Bubble_o(bub), .IFID_Flush_o(fl),
    .MemStall_o(ms), .Timeout_o(to), .StallCount_o(cnt)
  );

  hazard_stall_unit #(.TIMEOUT_CYCLES(4), .CNT_W(CNT_W)) dut4 (
    .clk_i(clk_i), .rst_i(rst4_n),
    .IDEX_MemRead_i(mr_ex), .IDEX_RegWrite_i(rw_ex),
    .IDEX_RegisterRt_i(rt_ex), .IDEX_RegisterRd_i(rd_ex),
    .EXMEM_MemRead_i(mr_mem), .EXMEM_RegisterRd_i(rd_mem),
    .IFID_RegisterRs_i(rs_id), .IFID_RegisterRt_i(rt_id), .Branch_i(br),
    .DMem_req_i(req), .DMem_ready_i(rdy),
    .PCWrite_o(pcw4), .IFIDWrite_o(ifw4), .IDEX_Bubble_o(bub4), .IFID_Flush_o(fl4),
    .MemStall_o(ms4), .Timeout_o(to4), .StallCount_o(cnt4)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  string step = "init";

  // Behavioural model of the main instance.
  bit m_halted, m_in_wait;
  int m_waited, m_stalls;
  bit e_pcw, e_ifw, e_bub, e_fl, e_ms, e_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", step, tag, obs, exp);
    end
  endtask

  function automatic bit src_hit(input logic [4:0] d);
    return (d != 5'd0) && (d == rs_id || d == rt_id);
  endfunction

  task automatic model_reset();
    m_halted = 0; m_in_wait = 0; m_waited = 0; m_stalls = 0;
  endtask

  task automatic drive(input bit a_mr, input logic [4:0] a_rt, input logic [4:0] a_rd,
                       input bit a_rw, input bit a_mmr, input logic [4:0] a_mrd,
                       input logic [4:0] a_rs, input logic [4:0] a_irt,
                       input bit a_br, input bit a_req, input bit a_rdy);
    mr_ex = a_mr; rt_ex = a_rt; rd_ex = a_rd; rw_ex = a_rw;
    mr_mem = a_mmr; rd_mem = a_mrd; rs_id = a_rs; rt_id = a_irt;
    br = a_br; req = a_req; rdy = a_rdy;
  endtask

  task automatic check_main();
    bit frz, hz;
    frz = m_halted || (m_in_wait ? !rdy : (req && !rdy));
    hz  = (mr_ex && src_hit(rt_ex)) || (br && rw_ex && src_hit(rd_ex)) ||
          (br && mr_mem && src_hit(rd_mem));
    e_pcw = !(frz || hz);
    e_ifw = e_pcw;
    e_bub = !frz && hz;
    e_fl  = !frz && !hz && br;
    e_ms  = frz;
    e_to  = m_halted;
    chk("pcw",   pcw, e_pcw);
    chk("ifw",   ifw, e_ifw);
    chk("bub",   bub, e_bub);
    chk("flush", fl,  e_fl);
    chk("mstl",  ms,  e_ms);
    chk("tout",  to,  e_to);
    chk("cnt",   cnt, m_stalls);
    $display("cyc %0d %s pcw=%0b bub=%0b fl=%0b ms=%0b to=%0b cnt=%0d",
             cyc, step, pcw, bub, fl, ms, to, cnt);
  endtask

  task automatic advance();
    @(posedge clk_i);
    cyc++;
    if (!e_pcw && m_stalls < CNT_MAX) m_stalls++;
    if (!m_halted) begin
      if (e_ms) begin
        if (m_in_wait) begin
          m_waited++;
          if (m_waited >= TO_MAIN) m_halted = 1;
        end else begin
          m_in_wait = 1;
          m_waited  = 0;
        end
      end else begin
        m_in_wait = 0;
        m_waited  = 0;
      end
    end
    #1;
  endtask

  task automatic do_cycle();
    @(negedge clk_i);
    check_main();
    advance();
  endtask

  initial begin
    rst_n = 1'b0; rst4_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    model_reset();
    #12;
    step = "reset";
    chk("pcw", pcw, 0); chk("ifw", ifw, 0); chk("bub", bub, 1); chk("flush", fl, 0);
    chk("mstl", ms, 0); chk("tout", to, 0); chk("cnt", cnt, 0);
    rst_n = 1'b1;
    @(posedge clk_i); #1;

    // Load-use on $8: one bubble cycle, count becomes 1.
    step = "ldu";
    drive(1, 8, 8, 1, 0, 0, 8, 0, 0, 0, 1);
    do_cycle();
    step = "ldu_after";
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk_i); check_main(); chk("cnt_is_1", cnt, 1); advance();

    // lw $8 then beq $8: two stalls, flush on the third cycle.
    step = "lwbeq1"; drive(1, 8, 8, 1, 0, 0, 8, 9, 1, 0, 1); do_cycle();
    step = "lwbeq2"; drive(0, 0, 0, 0, 1, 8, 8, 9, 1, 0, 1); do_cycle();
    step = "lwbeq3"; drive(0, 0, 0, 0, 0, 0, 8, 9, 1, 0, 1);
    @(negedge clk_i); check_main(); chk("flush_3rd", fl, 1); advance();

    // Register 0 never stalls; memory freeze beats branch flush.
    step = "r0";     drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1); do_cycle();
    step = "mem_br"; drive(0, 0, 0, 0, 0, 0, 3, 4, 1, 1, 0);
    @(negedge clk_i); check_main(); chk("no_flush", fl, 0); advance();
    step = "mem_br_rdy"; drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); do_cycle();

    // Five not-ready cycles, then ready, then back in RUN.
    step = "mem5";
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); check_main(); chk("ms_hi", ms, 1); advance();
    end
    step = "mem5_rdy"; rdy = 1'b1;
    @(negedge clk_i); check_main(); chk("ms_lo", ms, 0); advance();
    step = "mem5_run"; drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1); do_cycle();

    // Asynchronous reset in the middle of MEM_WAIT.
    step = "arst";
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    do_cycle(); do_cycle();
    rst_n = 1'b0; #1;
    chk("pcw", pcw, 0); chk("ifw", ifw, 0); chk("bub", bub, 1); chk("flush", fl, 0);
    chk("mstl", ms, 0); chk("tout", to, 0); chk("cnt", cnt, 0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 rst_n = 1'b1;
    step = "arst_run"; drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); do_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); do_cycle();

    // Timeout on the TIMEOUT_CYCLES=4 instance.
    step = "tmo";
    rst4_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i); check_main();
      chk("ms4", ms4, 1); chk("pcw4", pcw4, 0); chk("to4", to4, (k >= 5));
      advance();
    end
    step = "tmo_hold";
    drive(1, 2, 2, 1, 0, 0, 2, 0, 1, 1, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i); check_main();
      chk("to4", to4, 1); chk("pcw4", pcw4, 0); chk("fl4", fl4, 0); chk("bub4", bub4, 0);
      advance();
    end
    step = "tmo_rst";
    rst4_n = 1'b0; #1;
    chk("to4", to4, 0); chk("bub4", bub4, 1); chk("cnt4", cnt4, 0); chk("pcw4", pcw4, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    #1 rst4_n = 1'b1;
    @(negedge clk_i); check_main(); chk("fl4_run", fl4, 1); chk("to4", to4, 0); advance();

    // Randomized traffic on the main instance.
    step = "rand";
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
      do_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
